dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data_mem between two requesters: port 0 (CPU load/store
//  stage) and port 1 (program loader / debug DMA).
//  Round-robin grant with a req/gnt handshake; sequences one access at a time.
//  Drives data_mem's combinational write/read strobes only inside a dedicated ACCESS
//  cycle. Converts byte addresses to word indices, registers read data, and flags
//  misaligned or out-of-range accesses.
// PARAMETERS
//  MEM_SIZE  32  word depth of the attached data_mem; legal word index 0..MEM_SIZE-1
//  DATA_W    32  data width of requesters and memory
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       synchronous, active-high
//  pN_req (N=0,1)    in   1       request; held with its fields stable until pN_gnt
//  pN_we             in   1       1 = write, 0 = read
//  pN_addr           in   32      byte address; must be word-aligned
//  pN_wdata          in   DATA_W  write data
//  pN_gnt            out  1       1-cycle accept pulse
//  pN_rvalid         out  1       1-cycle completion pulse (reads and writes)
//  pN_rdata          out  DATA_W  read data, valid only with pN_rvalid
//  pN_err            out  1       with pN_rvalid: access rejected (misaligned/range)
//  mem_address       out  32      to data_mem.address (word index)
//  mem_data_in       out  DATA_W  to data_mem.data_in
//  mem_write_enable  out  1       to data_mem.write_enable
//  mem_read_enable   out  1       to data_mem.read_enable
//  mem_data_out      in   DATA_W  from data_mem.data_out
// BEHAVIOUR
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction per 3 cycles.
//  - Reset: state IDLE, rr pointer = port 0 preferred.
//    Reset value 0 for all gnt/rvalid/err/rdata outputs and all mem_* outputs.
//  IDLE, cycle T:
//  - If any req is asserted, the winner's pN_gnt = 1 (combinational, this cycle).
//  - The winner's we/addr/wdata and port ID are latched; state -> ACCESS.
//  - No req: stay in IDLE.
//  - Arbitration: one requester wins outright. If both request, the port named by
//    the rr pointer wins, then the pointer moves to the other port.
//    A loser keeps req high and wins the next IDLE.
//  ACCESS, cycle T+1:
//  - mem_address = latched_addr[31:2] zero-extended.
//  - mem_data_in = latched wdata.
//  - mem_write_enable = we; mem_read_enable = !we. Exactly one strobe is high.
//  - Legality is checked before strobing. Misaligned means addr[1:0] != 0.
//    Out of range means word index >= MEM_SIZE.
//    On either fault, both strobes stay 0 and the err flag is latched.
//  - Read data: rdata_q <= mem_data_out on a good read. rdata_q <= 0 on writes or
//    faults. State -> RESP.
//  RESP, cycle T+2:
//  - The owner's pN_rvalid = 1, pN_rdata = rdata_q, pN_err = err flag.
//  - All other outputs are 0. State -> IDLE; a new grant is possible at T+3.
//  Output quiescence:
//  - Outside ACCESS, mem_address, mem_data_in and both strobes are held at 0.
//    data_mem is level-sensitive, so no spurious write may occur.
//  - gnt/rvalid are never asserted to both ports in the same cycle.
//  Other rules:
//  - A req deasserted before gnt is simply not served. pN_req is ignored outside IDLE.
//  - Reset mid-transaction (ACCESS or RESP): abort to IDLE next edge with no rvalid.
//    The memory may already hold the write if reset arrives after ACCESS.
//  - Address arithmetic: word index = byte addr >> 2, no wrap. Indices >= MEM_SIZE
//    are errors, never aliased.
// STRUCTURE
//  - dmem_pkg holds: state enum {IDLE, ACCESS, RESP} (2-bit), PORT_CPU = 0,
//    PORT_DMA = 1, NUM_PORTS = 2.
//  - Sub-module rr_arbiter_2: req[1:0], advance -> gnt_onehot[1:0]; owns the rr
//    pointer and is instantiated once.
// TESTING
//  1. p0 write 0x0000_0008 <- 0xDEADBEEF, then p0 read 0x8.
//     -> p0_gnt at T, wr strobe at T+1 with mem_address = 2, p0_rvalid at T+2,
//        read returns 0xDEADBEEF, err = 0.
//  2. p0 and p1 both request reads in the same IDLE after reset.
//     -> p0 granted first, then p1 at T+3. Repeat -> p1 first (round-robin).
//  3. p1 read of 0x0000_0006 (misaligned) -> no mem strobe, p1_rvalid = 1,
//     p1_err = 1, p1_rdata = 0.
//  4. p0 write to 0x0000_0080 (index 32 = MEM_SIZE)
//     -> no strobe, err = 1, memory unchanged; write index 31 succeeds.
//  5. reset asserted during ACCESS of a p1 read -> no p1_rvalid, FSM IDLE next
//     cycle, pending p0_req granted the cycle after reset release.
//  6. Idle with no req for 10 cycles -> all mem_* outputs remain 0 every cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Word-index helper keeps byte-to-word conversion in one place.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int PORT_CPU  = 0;
  localparam int PORT_DMA  = 1;
  localparam int NUM_PORTS = 2;

  // Byte address to word index, zero-extended, no wrap.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side req/gnt bus for one arbiter port.
// The arbiter uses the slave modport; a requester uses the master modport.
interface dmem_req_if #(parameter int DATA_W = 32);

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer names the preferred port and
// only moves when both ports contend for a taken grant.
module rr_arbiter_2
  import dmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_PORTS-1:0] o_gnt_onehot
);

  logic r_ptr;
  logic w_both;

  assign w_both = i_req[PORT_CPU] & i_req[PORT_DMA];

  always_comb begin
    o_gnt_onehot = i_req;
    if (w_both) begin
      o_gnt_onehot = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (i_advance && w_both) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port, level-sensitive data_mem between CPU (port 0) and
// DMA (port 1); one IDLE -> ACCESS -> RESP transaction at a time.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_req_if.slave         p0,
  dmem_req_if.slave         p1,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t r_state;
  state_t w_next;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt_oh;
  logic                 w_take;
  logic                 w_misal;
  logic                 w_oor;
  logic                 w_legal;

  logic              r_owner;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  assign w_req   = {p1.req, p0.req};
  assign w_take  = (r_state == IDLE) && (|w_req) && !reset;
  assign w_misal = (r_addr[1:0] != 2'b00);
  assign w_oor   = (word_index(r_addr) >= 32'(MEM_SIZE));
  assign w_legal = !w_misal && !w_oor;

  rr_arbiter_2 u_rr (
    .clk          (clk),
    .reset        (reset),
    .i_req        (w_req),
    .i_advance    (w_take),
    .o_gnt_onehot (w_gnt_oh)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are gated by reset so an aborted transaction never pulses gnt/rvalid.
  always_comb begin
    w_next           = r_state;
    p0.gnt           = 1'b0;
    p1.gnt           = 1'b0;
    p0.rvalid        = 1'b0;
    p1.rvalid        = 1'b0;
    p0.rdata         = '0;
    p1.rdata         = '0;
    p0.err           = 1'b0;
    p1.err           = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_next = ACCESS;
          p0.gnt = w_gnt_oh[PORT_CPU];
          p1.gnt = w_gnt_oh[PORT_DMA];
        end
      end
      ACCESS: begin
        w_next = RESP;
        if (w_legal && !reset) begin
          mem_address      = word_index(r_addr);
          mem_data_in      = r_wdata;
          mem_write_enable = r_we;
          mem_read_enable  = !r_we;
        end
      end
      RESP: begin
        w_next = IDLE;
        if (!reset) begin
          if (r_owner == 1'(PORT_DMA)) begin
            p1.rvalid = 1'b1;
            p1.rdata  = r_rdata;
            p1.err    = r_err;
          end else begin
            p0.rvalid = 1'b1;
            p0.rdata  = r_rdata;
            p0.err    = r_err;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_owner <= w_gnt_oh[PORT_DMA];
        r_we    <= w_gnt_oh[PORT_DMA] ? p1.we    : p0.we;
        r_addr  <= w_gnt_oh[PORT_DMA] ? p1.addr  : p0.addr;
        r_wdata <= w_gnt_oh[PORT_DMA] ? p1.wdata : p0.wdata;
      end
      if (r_state == ACCESS) begin
        r_err   <= !w_legal;
        r_rdata <= (w_legal && !r_we) ? mem_data_out : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an attached data_mem model and a
// response scoreboard checked whenever a port signals rvalid.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MEM_SIZE = 32;
  localparam int DATA_W   = 32;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_data_out;

  logic [31:0] mem     [MEM_SIZE];
  logic [31:0] ref_mem [MEM_SIZE];
  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;

  dmem_req_if #(.DATA_W(DATA_W)) p0_if ();
  dmem_req_if #(.DATA_W(DATA_W)) p1_if ();

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .p0               (p0_if),
    .p1               (p1_if),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_data_out     (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached data_mem: combinational read, level-sensitive write on the clock edge.
  assign mem_data_out = mem_read_enable ? mem[mem_address[4:0]] : '0;
  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'hA500_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (mem_write_enable && mem_address < 32'(MEM_SIZE)) mem[mem_address[4:0]] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) p0_if.req = 1'b0;
    else           p1_if.req = 1'b0;
  endtask

  // Runs one transaction from an IDLE cycle; called just after a rising edge.
  task automatic xact(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    logic        ok;
    logic [31:0] idx;
    exp_t        e;
    ok  = (addr[1:0] == 2'b00) && ((addr >> 2) < 32'(MEM_SIZE));
    idx = addr >> 2;
    issue(port, we, addr, wdata);
    @(negedge clk);
    check("gnt_winner", (port == 0) ? p0_if.gnt : p1_if.gnt, 1);
    check("gnt_loser",  (port == 0) ? p1_if.gnt : p0_if.gnt, 0);
    e.port  = port;
    e.err   = !ok;
    e.rdata = (ok && !we) ? ref_mem[idx[4:0]] : 32'h0;
    sb.push_back(e);
    if (ok && we) ref_mem[idx[4:0]] = wdata;
    @(posedge clk); #1;
    drop(port);
    @(negedge clk);
    check("access_we", mem_write_enable, ok && we);
    check("access_re", mem_read_enable,  ok && !we);
    check("access_gnt", {p0_if.gnt, p1_if.gnt}, 0);
    if (ok) check("access_addr", mem_address, idx);
    if (ok && we) check("access_wdata", mem_data_in, wdata);
    @(negedge clk);
    check("resp_rvalid", (port == 0) ? p0_if.rvalid : p1_if.rvalid, 1);
    check("resp_strobes", {mem_write_enable, mem_read_enable}, 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every rvalid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (p0_if.gnt === 1'b1 && p1_if.gnt === 1'b1) check("gnt_both", 1, 0);
      if (p0_if.rvalid === 1'b1 || p1_if.rvalid === 1'b1) begin
        if (p0_if.rvalid === 1'b1 && p1_if.rvalid === 1'b1) check("rvalid_both", 1, 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_rvalid observed=p0:%b/p1:%b expected=none",
                 p0_if.rvalid, p1_if.rvalid);
        end else begin
          mon_e = sb.pop_front();
          check("sb_port", {31'b0, p1_if.rvalid}, 32'(mon_e.port));
          check("sb_rdata", (mon_e.port == 0) ? p0_if.rdata : p1_if.rdata, mon_e.rdata);
          check("sb_err",   (mon_e.port == 0) ? p0_if.err   : p1_if.err,   {31'b0, mon_e.err});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    reset = 1'b1;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;

    // Reset state, with a request held to show gnt stays low.
    repeat (2) @(posedge clk);
    #1 p0_if.req = 1'b1;
    @(negedge clk);
    check("rst_gnt",    {p0_if.gnt, p1_if.gnt}, 0);
    check("rst_rvalid", {p0_if.rvalid, p1_if.rvalid}, 0);
    check("rst_err",    {p0_if.err, p1_if.err}, 0);
    check("rst_rdata0", p0_if.rdata, 0);
    check("rst_rdata1", p1_if.rdata, 0);
    check("rst_mem",    {mem_address[0], mem_write_enable, mem_read_enable}, 0);
    check("rst_maddr",  mem_address, 0);
    check("rst_mdin",   mem_data_in, 0);
    @(posedge clk); #1;
    p0_if.req = 1'b0;
    reset = 1'b0;

    // Write then read back on the CPU port.
    xact(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    xact(0, 1'b0, 32'h0000_0008, 32'h0);

    // Contention: port 0 preferred first, then round-robin flips to port 1.
    issue(1, 1'b0, 32'h0000_0004, 32'h0);
    xact(0, 1'b0, 32'h0000_000C, 32'h0);
    xact(1, 1'b0, 32'h0000_0004, 32'h0);
    issue(0, 1'b0, 32'h0000_0014, 32'h0);
    xact(1, 1'b0, 32'h0000_0018, 32'h0);
    xact(0, 1'b0, 32'h0000_0014, 32'h0);

    // Misaligned read on the DMA port.
    xact(1, 1'b0, 32'h0000_0006, 32'h0);

    // Out-of-range write must not alias index 0; the last legal index works.
    xact(0, 1'b1, 32'h0000_0080, 32'h5555_5555);
    xact(0, 1'b0, 32'h0000_0000, 32'h0);
    check("mem0_untouched", mem[0], 32'hA500_0000);
    xact(0, 1'b1, 32'h0000_007C, 32'h1234_5678);
    xact(1, 1'b0, 32'h0000_007C, 32'h0);
    check("mem31_written", mem[31], 32'h1234_5678);
    xact(1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    xact(0, 1'b0, 32'h0000_0010, 32'h0);

    // Reset during ACCESS of a DMA read: no response, pending CPU request served next.
    issue(1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    check("abort_gnt", p1_if.gnt, 1);
    @(posedge clk); #1;
    drop(1);
    issue(0, 1'b0, 32'h0000_0008, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rvalid", {p0_if.rvalid, p1_if.rvalid}, 0);
    check("abort_gnt_low", {p0_if.gnt, p1_if.gnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    xact(0, 1'b0, 32'h0000_0008, 32'h0);

    // Idle quiescence.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_maddr", mem_address, 0);
      check("idle_mdin",  mem_data_in, 0);
      check("idle_strb",  {mem_write_enable, mem_read_enable}, 0);
    end

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
